sr_latch_sequencer: RTL and testbench
=====================================

# sr_latch_sequencer

Clocked controller that shares one cross-coupled SR latch (2-input or preset/reset variant) between `NREQ` requesters. It arbitrates set/reset requests round-robin, drives the latch S/R inputs with fixed-width pulses, and never asserts S and R together, so the forbidden 11 input never occurs. After a settle interval it checks the synchronized latch output against the commanded value and acknowledges the requester. It sits between the synchronous command logic and the asynchronous latch primitives.

## Interface
- `NREQ`, 4: number of requesters, ≥2.
- `PULSE_W`, 2: S/R pulse width in cycles, ≥1.
- `SETTLE_W`, 2: cycles with S=R=0 before the check, ≥2 (covers the synchronizer).

- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: request per requester; held until its `ack`.
- `op`  in  NREQ: per-requester command, 1 = set (Q→1), 0 = reset (Q→0); sampled at grant.
- `q_in`  in  1: latch Q output, asynchronous to `clk`.
- `s_out`  out  1: latch S drive.
- `r_out`  out  1: latch R drive.
- `ack`  out  NREQ: one-hot, one-cycle completion pulse.
- `err`  out  1: one-cycle pulse with `ack` when Q ≠ commanded value.
- `busy`  out  1: high in every state except IDLE.
- `q_state`  out  1: last synchronized Q value.

## Operation
- States: IDLE, PULSE, SETTLE, CHECK.
- IDLE: if `req` ≠ 0, grant the first set bit at or after `ptr`, searching upward and wrapping. Latch the grant index and `op[idx]` as `tgt`, then go to PULSE. With no request, stay in IDLE.
- PULSE: drive `s_out` = `tgt`, `r_out` = ~`tgt` for `PULSE_W` cycles, then go to SETTLE.
- SETTLE: `s_out` = `r_out` = 0 for `SETTLE_W` cycles, then go to CHECK.
- CHECK: one cycle. Assert `ack[idx]`; assert `err` if sync(`q_in`) ≠ `tgt`. Set `ptr` ← (idx+1) mod NREQ, then go to IDLE.
- `q_in` passes through a 2-flop synchronizer. `q_state` follows the second flop in every state.
- Invariant: `s_out & r_out` = 0 in every cycle, including reset.
- All outputs are registered. `ack`, `err`, `s_out` and `r_out` are Moore outputs of the state register.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `s_out` = `r_out` = 0, `ack` = 0, `err` = 0, `busy` = 0, synchronizer = 0, `q_state` = 0.
- Reset mid-operation: `s_out` and `r_out` drop asynchronously with `rst_n`. No `ack` is issued for the aborted op.
- Latency: request sampled in IDLE at edge 0 → `s_out`/`r_out` high for edges 1..PULSE_W → `ack` in cycle 1+PULSE_W+SETTLE_W (cycle 5 at defaults). Issue interval is 2+PULSE_W+SETTLE_W cycles (6 at defaults).
- Back-to-back: IDLE always lasts at least one cycle between operations.
- `req[idx]` dropped after grant: the operation still completes and `ack[idx]` still pulses. A `req` bit raised during `busy` is considered at the next IDLE.
- Simultaneous requests: the winner is the first set bit at or after `ptr`. No requester waits more than NREQ−1 operations.
- `op` is ignored except at grant. A requester commanding the value Q already holds still gets a full pulse, and `err` = 0.
- Counter widths: $clog2(max(PULSE_W,SETTLE_W)+1). The counter resets to 0 on every state entry.

## Structure
- Package `sr_seq_pkg` holds:
  - `state_t` enum {IDLE, PULSE, SETTLE, CHECK};
  - `OP_SET` = 1'b1, `OP_RESET` = 1'b0.
- Sub-module `rr_arbiter`, parameterized by NREQ. Inputs: `req`, `ptr`. Outputs: `gnt` (one-hot), `gnt_idx`, `any`. Purely combinational.
- Top module holds the FSM, pulse/settle counter, synchronizer, `ptr` register and `tgt`/`idx` registers.
- Elaboration-time checks: `PULSE_W` ≥ 1, `SETTLE_W` ≥ 2, `NREQ` ≥ 2.

## Test plan
- Reset: hold `rst_n` = 0 with `req` = 4'b1111 → all outputs 0, `busy` = 0. Release → grant goes to requester 0 (`ptr` = 0).
- Single set: `req` = 4'b0100, `op[2]` = 1, latch model driven by S/R → `s_out` high for cycles 1–2, `r_out` = 0 throughout, `ack` = 4'b0100 at cycle 5, `err` = 0, `q_state` = 1.
- Round-robin: `req` = 4'b1011 held, alternating ops → ack order 0, 1, 3, 0 at 6-cycle intervals. No S and R overlap is ever seen.
- Fault: `q_in` tied to 0 with a set request → `ack` plus `err` = 1 in the same cycle, and `q_state` = 0.
- Abort: assert `rst_n` = 0 in the second PULSE cycle → `s_out` falls in the same cycle, no `ack`. After release, `ptr` = 0 and a pending request restarts from IDLE.
- Drop: deassert `req[1]` in SETTLE → `ack[1]` still pulses at cycle 5. With `req[1]` = 0 afterwards, it is not regranted.

Source files
------------

// File: rtl/sr_seq_pkg.sv
// Shared types and constants for the SR latch sequencer.
//   state_t  : sequencer FSM states
//   OP_SET   : command value driving Q to 1
//   OP_RESET : command value driving Q to 0
package sr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit at or
// after ptr, searching upward and wrapping.
//   req     : request vector
//   ptr     : search start index
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of the granted bit (zero when no request)
//   any     : at least one request is pending
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdxW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IdxW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IdxW-1:0] gnt_idx,
    output logic            any
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IdxW'((32'(ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt = any ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Shares one SR latch between NREQ requesters. Requests are arbitrated
// round-robin; the winner's command is applied as a PULSE_W-cycle S or R pulse,
// followed by SETTLE_W idle cycles, then the synchronized Q is checked and the
// requester acknowledged. S and R are never driven together.
//   clk, rst_n : clock, async active-low reset
//   req, op    : per-requester request and command (1 = set, 0 = reset)
//   q_in       : latch Q, asynchronous to clk
//   s_out/r_out: latch drives (registered)
//   ack, err   : one-cycle completion pulse (one-hot) and mismatch flag
//   busy       : not in IDLE
//   q_state    : synchronized Q
module sr_latch_sequencer
    import sr_seq_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned PULSE_W  = 2,
    parameter int unsigned SETTLE_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    input  logic            q_in,
    output logic            s_out,
    output logic            r_out,
    output logic [NREQ-1:0] ack,
    output logic            err,
    output logic            busy,
    output logic            q_state
);

    localparam int unsigned MaxW = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
    localparam int unsigned CntW = $clog2(MaxW + 1);
    localparam int unsigned IdxW = $clog2(NREQ);

    if (NREQ < 2) begin : g_chk_nreq
        $error("NREQ must be at least 2");
    end
    if (PULSE_W < 1) begin : g_chk_pulse
        $error("PULSE_W must be at least 1");
    end
    if (SETTLE_W < 2) begin : g_chk_settle
        $error("SETTLE_W must be at least 2");
    end

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            tgt_q, tgt_d;
    logic [1:0]      sync_q;
    logic            s_q, s_d, r_q, r_d, err_q, err_d, busy_q, busy_d;
    logic [NREQ-1:0] ack_q, ack_d;

    logic [NREQ-1:0] gnt;
    logic [IdxW-1:0] gnt_idx;
    logic            any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    idx_d   = gnt_idx;
                    tgt_d   = |(op & gnt);
                    cnt_d   = '0;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == CntW'(PULSE_W - 1)) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CntW'(SETTLE_W - 1)) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            CHECK: begin
                ptr_d   = (idx_q == IdxW'(NREQ - 1)) ? '0 : idx_q + IdxW'(1);
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail it by one
    // cycle; S and R are mutually exclusive by construction on tgt_q.
    always_comb begin
        s_d    = (state_q == PULSE) && (tgt_q == OP_SET);
        r_d    = (state_q == PULSE) && (tgt_q == OP_RESET);
        ack_d  = (state_q == CHECK) ? (NREQ'(1) << idx_q) : '0;
        err_d  = (state_q == CHECK) && (sync_q[1] != tgt_q);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            tgt_q   <= 1'b0;
            sync_q  <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            sync_q  <= {sync_q[0], q_in};
            s_q     <= s_d;
            r_q     <= r_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign s_out   = s_q;
    assign r_out   = r_q;
    assign ack     = ack_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign q_state = sync_q[1];

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed self-checking bench for sr_latch_sequencer at default parameters.
module tb_sr_latch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] op = 4'b0000;
    logic       q_in;
    logic       s_out, r_out, err, busy, q_state;
    logic [3:0] ack;

    logic latch_q = 1'b0;
    logic fault = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural SR latch; fault pins the observed Q low.
    always @(s_out or r_out) begin
        if (s_out) latch_q = 1'b1;
        else if (r_out) latch_q = 1'b0;
    end
    assign q_in = fault ? 1'b0 : latch_q;

    sr_latch_sequencer u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op      (op),
        .q_in    (q_in),
        .s_out   (s_out),
        .r_out   (r_out),
        .ack     (ack),
        .err     (err),
        .busy    (busy),
        .q_state (q_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) check_eq("no_overlap", {31'b0, s_out & r_out}, 32'd0);

    // Starts in IDLE just before the granting edge; ends in cycle 5 (ack cycle).
    task automatic run_op(input int idx, input logic tgt, input logic exp_err,
                          input int drop_cycle);
        logic [3:0] exp_ack;
        step();
        check_eq($sformatf("busy_c0_r%0d", idx), {31'b0, busy}, 32'd1);
        for (int c = 1; c <= 5; c++) begin
            step();
            exp_ack = (c == 5) ? (4'b0001 << idx) : 4'b0000;
            check_eq($sformatf("s_out_c%0d_r%0d", c, idx), {31'b0, s_out},
                     {31'b0, (c == 1 || c == 2) && tgt});
            check_eq($sformatf("r_out_c%0d_r%0d", c, idx), {31'b0, r_out},
                     {31'b0, (c == 1 || c == 2) && !tgt});
            check_eq($sformatf("ack_c%0d_r%0d", c, idx), {28'b0, ack}, {28'b0, exp_ack});
            check_eq($sformatf("err_c%0d_r%0d", c, idx), {31'b0, err},
                     {31'b0, (c == 5) && exp_err});
            check_eq($sformatf("busy_c%0d_r%0d", c, idx), {31'b0, busy}, {31'b0, c < 5});
            if (c == drop_cycle) req = 4'b0000;
        end
    endtask

    initial begin
        // Reset with all requests pending.
        req = 4'b1111;
        op  = 4'b0000;
        step();
        step();
        check_eq("rst_s_out", {31'b0, s_out}, 32'd0);
        check_eq("rst_r_out", {31'b0, r_out}, 32'd0);
        check_eq("rst_ack", {28'b0, ack}, 32'd0);
        check_eq("rst_err", {31'b0, err}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_q_state", {31'b0, q_state}, 32'd0);
        rst_n = 1'b1;
        run_op(0, 1'b0, 1'b0, -1);  // ptr = 0 wins requester 0
        req = 4'b0000;

        // Single set on requester 2.
        op  = 4'b0100;
        req = 4'b0100;
        run_op(2, 1'b1, 1'b0, -1);
        check_eq("set_q_state", {31'b0, q_state}, 32'd1);
        req = 4'b0000;

        // Fault: Q stuck low while requester 3 commands a set.
        fault = 1'b1;
        op    = 4'b1000;
        req   = 4'b1000;
        run_op(3, 1'b1, 1'b1, -1);
        check_eq("fault_q_state", {31'b0, q_state}, 32'd0);
        req   = 4'b0000;
        fault = 1'b0;

        // Round-robin with 1011 held from ptr = 0: 0, 1, 3, 0.
        op  = 4'b1001;
        req = 4'b1011;
        run_op(0, 1'b1, 1'b0, -1);
        op = 4'b1000;
        run_op(1, 1'b0, 1'b0, -1);
        run_op(3, 1'b1, 1'b0, -1);
        run_op(0, 1'b0, 1'b0, -1);
        req = 4'b0000;

        // Drop req[1] in SETTLE; op still completes and is not regranted.
        op  = 4'b0010;
        req = 4'b0010;
        run_op(1, 1'b1, 1'b0, 3);
        check_eq("drop_q_state", {31'b0, q_state}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("drop_idle_busy%0d", i), {31'b0, busy}, 32'd0);
            check_eq($sformatf("drop_idle_ack%0d", i), {28'b0, ack}, 32'd0);
        end

        // Abort: ptr = 2 grants requester 3; reset in its second PULSE cycle.
        op  = 4'b1001;
        req = 4'b1001;
        step();
        step();
        check_eq("abort_s_before", {31'b0, s_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_s_async", {31'b0, s_out}, 32'd0);
        check_eq("abort_busy_async", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq($sformatf("abort_ack%0d", i), {28'b0, ack}, 32'd0);
            check_eq($sformatf("abort_s%0d", i), {31'b0, s_out}, 32'd0);
        end
        rst_n = 1'b1;
        run_op(0, 1'b1, 1'b0, -1);  // ptr back at 0 picks requester 0, not 3
        req = 4'b0000;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
